// File: rtl/sap2_pkg.sv
// sap2_pkg: shared SAP-II bus width, bus constants and receiver state encoding
package sap2_pkg;
    localparam int WORD_W = 8;
    localparam logic [WORD_W-1:0] HIGH_IMPEDANCE = {WORD_W{1'bz}};
    localparam logic [WORD_W-1:0] ZERO_STATE = '0;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
endpackage

// File: rtl/sin_synchronizer.sv
// sin_synchronizer: 2-flop synchronizer for the idle-high serial line
//   CLK clock, CLR sync active-high reset (flops to 1), d async input, q synchronized output
module sin_synchronizer (
    input  logic CLK,
    input  logic CLR,
    input  logic d,
    output logic q
);
    logic meta;
    always_ff @(posedge CLK) begin
        if (CLR) {q, meta} <= 2'b11;
        else {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/serial_in_port.sv
// serial_in_port: SAP-II serial receiver that buffers framed bytes and drives them onto WBUS
//   CLK clock, CLR sync active-high reset, WBUS tri-state bus (buffer when Ei), SIN serial line,
//   TICK baud strobe, Ei bus read enable, READY unread byte, OVR overrun, FERR bad-stop pulse
//   Optional PARITY_CHECK_EN: even-parity bit before stop, adds PERR pulse output
module serial_in_port
    import sap2_pkg::*;
#(
    parameter int TICKS_PER_BIT = 16,
    parameter int WORD_W = sap2_pkg::WORD_W
) (
    input  logic              CLK,
    input  logic              CLR,
    inout  wire  [WORD_W-1:0] WBUS,
    input  logic              SIN,
    input  logic              TICK,
    input  logic              Ei,
    output logic              READY,
    output logic              OVR,
`ifdef PARITY_CHECK_EN
    output logic              PERR,
`endif
    output logic              FERR
);
`ifdef PARITY_CHECK_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int SR_W = WORD_W + PB;
    localparam int TW = $clog2(TICKS_PER_BIT);
    localparam int BW = $clog2(SR_W + 1);

    rx_state_t state, state_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic [BW-1:0] bcnt, bcnt_n;
    logic [SR_W-1:0] sr, sr_n;
    logic [WORD_W-1:0] buffer;
    logic sin_s, stop_hit, parity_ok, half_done, bit_done, frame_good, frame_bad;

    sin_synchronizer u_sync (.CLK(CLK), .CLR(CLR), .d(SIN), .q(sin_s));

    assign WBUS = Ei ? buffer : HIGH_IMPEDANCE;
    assign half_done = tcnt == TW'(TICKS_PER_BIT / 2 - 1);
    assign bit_done = tcnt == TW'(TICKS_PER_BIT - 1);
`ifdef PARITY_CHECK_EN
    // data and parity sit together in sr, so even parity means the whole word XORs to 0
    assign parity_ok = ~^sr;
`else
    assign parity_ok = 1'b1;
`endif
    assign frame_good = stop_hit & sin_s & parity_ok;
    assign frame_bad = stop_hit & ~sin_s;

    always_comb begin
        state_n = state;
        tcnt_n = tcnt;
        bcnt_n = bcnt;
        sr_n = sr;
        stop_hit = 1'b0;
        if (TICK) begin
            case (state)
                IDLE: if (!sin_s) begin
                    state_n = START;
                    tcnt_n = '0;
                end
                START: if (half_done) begin
                    state_n = sin_s ? IDLE : DATA;
                    tcnt_n = '0;
                    bcnt_n = '0;
                end else tcnt_n = tcnt + 1'b1;
                DATA: if (bit_done) begin
                    sr_n = {sin_s, sr[SR_W-1:1]};
                    tcnt_n = '0;
                    bcnt_n = bcnt + 1'b1;
                    state_n = (bcnt == BW'(SR_W - 1)) ? STOP : DATA;
                end else tcnt_n = tcnt + 1'b1;
                STOP: if (bit_done) begin
                    state_n = IDLE;
                    tcnt_n = '0;
                    stop_hit = 1'b1;
                end else tcnt_n = tcnt + 1'b1;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state <= IDLE;
            tcnt <= '0;
            bcnt <= '0;
            sr <= '0;
            buffer <= ZERO_STATE;
            READY <= 1'b0;
            OVR <= 1'b0;
            FERR <= 1'b0;
`ifdef PARITY_CHECK_EN
            PERR <= 1'b0;
`endif
        end else begin
            state <= state_n;
            tcnt <= tcnt_n;
            bcnt <= bcnt_n;
            sr <= sr_n;
            FERR <= frame_bad;
`ifdef PARITY_CHECK_EN
            PERR <= stop_hit & ~parity_ok;
`endif
            // a read coinciding with a new byte consumes the old byte, so no overrun
            if (frame_good) begin
                buffer <= sr[WORD_W-1:0];
                READY <= 1'b1;
                OVR <= READY & ~Ei;
            end else if (Ei) begin
                READY <= 1'b0;
                OVR <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_serial_in_port.sv
// tb_serial_in_port: table-driven and randomized checks of serial_in_port against a frame-level model
module tb_serial_in_port;
    localparam int TPB = 4;
`ifdef PARITY_CHECK_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0, clr = 1'b1, sin = 1'b1, tick = 1'b1, ei = 1'b0;
    logic ready, ovr, ferr;
    wire [7:0] wbus;
`ifdef PARITY_CHECK_EN
    logic perr;
`endif

    for (genvar g = 0; g < 8; g++) begin : pu
        pullup (wbus[g]);
    end

    serial_in_port #(.TICKS_PER_BIT(TPB), .WORD_W(8)) dut (
        .CLK(clk), .CLR(clr), .WBUS(wbus), .SIN(sin), .TICK(tick), .Ei(ei),
        .READY(ready), .OVR(ovr),
`ifdef PARITY_CHECK_EN
        .PERR(perr),
`endif
        .FERR(ferr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int ferr_cnt = 0, perr_cnt = 0;

    always @(negedge clk) begin
        if (ferr === 1'b1) ferr_cnt++;
`ifdef PARITY_CHECK_EN
        if (perr === 1'b1) perr_cnt++;
`endif
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // frame-level reference: what a CPU would see after each complete frame or read
    bit m_ready = 0, m_ovr = 0;
    logic [7:0] m_buf = 8'h00;
    int m_ferr = 0, m_perr = 0;

    task automatic model_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok, input bit rd);
        if (stop_ok && par_ok) begin
            m_ovr = m_ready && !rd;
            m_ready = 1;
            m_buf = d;
        end else if (rd) begin
            m_ready = 0;
            m_ovr = 0;
        end
        if (!stop_ok) m_ferr++;
        if (!par_ok) m_perr++;
    endtask

    task automatic model_read();
        m_ready = 0;
        m_ovr = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok, input int clr_k);
        logic [NB-1:0] bits;
`ifdef PARITY_CHECK_EN
        bits = {stop_ok, (^d) ^ !par_ok, d, 1'b0};
`else
        bits = {stop_ok, d, 1'b0};
`endif
        for (int k = 0; k < NB * TPB; k++) begin
            @(negedge clk);
            sin = bits[k / TPB];
            ei = 1'b0;
            if (k == clr_k) begin
                clr = 1'b1;
                @(negedge clk);
                clr = 1'b0;
                sin = 1'b1;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sin = 1'b1;
            ei = 1'b0;
        end
    endtask

    task automatic read_chk(input string nm, input logic [7:0] exp);
        @(negedge clk);
        ei = 1'b1;
        #1 chk({nm, "_wbus"}, wbus, exp);
        @(negedge clk);
        ei = 1'b0;
        #1 chk({nm, "_ready_after_read"}, ready, 0);
        chk({nm, "_ovr_after_read"}, ovr, 0);
        model_read();
    endtask

    typedef struct {
        logic [7:0] d;
        bit stop_ok;
        bit rd;
        bit exp_ready;
        bit exp_ovr;
        int exp_ferr;
        logic [7:0] exp_buf;
    } vec_t;

    vec_t vt[4];

    initial begin
        int f0;
        bit prev_bad;
        vt[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1, 8'hA5};
        vt[0].exp_ferr = 0;
        vt[1] = '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1, 8'hA5};
        vt[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 0, 8'h3C};
        vt[3] = '{8'h81, 1'b1, 1'b1, 1'b1, 1'b1, 0, 8'h81};

        repeat (2) @(negedge clk);
        clr = 1'b0;
        #1 chk("rst_ready", ready, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_wbus_released", wbus, 8'hFF);
        @(negedge clk);
        ei = 1'b1;
        #1 chk("rst_wbus_read", wbus, 8'h00);
        @(negedge clk);
        ei = 1'b0;

        for (int i = 0; i < 4; i++) begin
            f0 = ferr_cnt;
            send_frame(vt[i].d, vt[i].stop_ok, 1'b1, -1);
            idle(2 * TPB);
            model_frame(vt[i].d, vt[i].stop_ok, 1'b1, 1'b0);
            #1 chk($sformatf("vec%0d_ready", i), ready, vt[i].exp_ready);
            chk($sformatf("vec%0d_ovr", i), ovr, vt[i].exp_ovr);
            chk($sformatf("vec%0d_ferr_pulses", i), ferr_cnt - f0, vt[i].exp_ferr);
            if (vt[i].rd) read_chk($sformatf("vec%0d", i), vt[i].exp_buf);
        end

        f0 = ferr_cnt;
        @(negedge clk);
        sin = 1'b0;
        @(negedge clk);
        sin = 1'b1;
        idle(3 * TPB);
        #1 chk("glitch_ready", ready, 0);
        chk("glitch_ferr_pulses", ferr_cnt - f0, 0);
        read_chk("glitch", 8'h81);

        send_frame(8'h11, 1'b1, 1'b1, -1);
        idle(2 * TPB);
        model_frame(8'h11, 1'b1, 1'b1, 1'b0);
        send_frame(8'h42, 1'b1, 1'b1, -1);
        @(negedge clk);
        sin = 1'b1;
        ei = 1'b1;
        #1 chk("stop_read_old_wbus", wbus, 8'h11);
        @(negedge clk);
        ei = 1'b0;
        model_frame(8'h42, 1'b1, 1'b1, 1'b1);
        #1 chk("stop_read_ready", ready, 1);
        chk("stop_read_ovr", ovr, 0);
        idle(TPB);
        read_chk("stop_read", 8'h42);

        send_frame(8'h66, 1'b1, 1'b1, -1);
        idle(2 * TPB);
        model_frame(8'h66, 1'b1, 1'b1, 1'b0);
        f0 = ferr_cnt;
        send_frame(8'h99, 1'b1, 1'b1, 4 * TPB + 1);
        m_ready = 0;
        m_ovr = 0;
        m_buf = 8'h00;
        idle(2);
        #1 chk("clr_mid_ready", ready, 0);
        chk("clr_mid_ovr", ovr, 0);
        chk("clr_mid_ferr_pulses", ferr_cnt - f0, 0);
        read_chk("clr_mid", 8'h00);
        idle(2 * TPB);
        send_frame(8'h5A, 1'b1, 1'b1, -1);
        idle(2 * TPB);
        model_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        #1 chk("after_clr_ready", ready, 1);
        read_chk("after_clr", 8'h5A);

        m_ferr = ferr_cnt;
        m_perr = perr_cnt;
        prev_bad = 0;
        for (int i = 0; i < 40; i++) begin
            logic [7:0] d;
            bit stop_ok, par_ok, rd, ei_stop;
            int gap;
            d = 8'($urandom);
            stop_ok = $urandom_range(0, 5) != 0;
`ifdef PARITY_CHECK_EN
            par_ok = $urandom_range(0, 5) != 0;
`else
            par_ok = 1'b1;
`endif
            gap = prev_bad ? $urandom_range(2, 5) : $urandom_range(0, 5);
            rd = $urandom_range(0, 1) == 1;
            ei_stop = gap >= 1 && $urandom_range(0, 3) == 0;
            send_frame(d, stop_ok, par_ok, -1);
            for (int j = 0; j < gap; j++) begin
                @(negedge clk);
                sin = 1'b1;
                ei = (j == 0 && ei_stop) || (j == 1 && rd);
                if (j == 0) model_frame(d, stop_ok, par_ok, ei_stop);
                if (j == 1) begin
                    #1 chk($sformatf("rnd%0d_ready", i), ready, m_ready);
                    chk($sformatf("rnd%0d_ovr", i), ovr, m_ovr);
                    chk($sformatf("rnd%0d_ferr_total", i), ferr_cnt, m_ferr);
                    chk($sformatf("rnd%0d_perr_total", i), perr_cnt, m_perr);
                    if (rd) begin
                        chk($sformatf("rnd%0d_wbus", i), wbus, m_buf);
                        model_read();
                    end
                end
            end
            if (gap == 0) model_frame(d, stop_ok, par_ok, 1'b0);
            prev_bad = !stop_ok;
        end
        idle(3 * TPB);
        #1 chk("final_ready", ready, m_ready);
        chk("final_ovr", ovr, m_ovr);
        chk("final_ferr_total", ferr_cnt, m_ferr);
        read_chk("final", m_buf);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
